// File: rtl/dmux_pkg.sv
// Shared definitions for the design mux: FSM state encoding, the "no design"
// select helper and the sequencing counter width.
package dmux_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GUARD = 2'd1,
        ST_RESET = 2'd2
    } dmux_state_e;

    function automatic logic [31:0] sel_none(input int unsigned sel_w);
        return (32'd1 << sel_w) - 32'd1;
    endfunction

    // One counter serves both GUARD and RESET, so it must hold the longer count.
    function automatic int unsigned cnt_width(input int unsigned guard_cycles,
                                              input int unsigned reset_cycles);
        int unsigned longest;
        longest = (guard_cycles > reset_cycles) ? guard_cycles : reset_cycles;
        return (longest <= 32'd2) ? 32'd1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/dmux_sync.sv
// Synchroniser for the asynchronous LA configuration strobe, followed by a
// registered rising-edge detector producing a one-cycle commit pulse.
module dmux_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic pulse_o
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;
    logic              pulse_q;

    // Metastability chain plus edge detection; cleared by the synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q  <= '0;
            last_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], async_i};
            last_q  <= sync_q[STAGES-1];
            pulse_q <= sync_q[STAGES-1] & ~last_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/design_mux_gen2.sv
// Routes the shared IO pads to one of N_DESIGNS user designs and sequences each
// selection change (blank, switch, reset). Option: DMUX_REGISTERED_IO_EN.
module design_mux_gen2
    import dmux_pkg::*;
#(
    parameter int unsigned N_DESIGNS    = 8,
    parameter int unsigned SEL_W        = 4,
    parameter int unsigned IO_W         = 38,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned RESET_CYCLES = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_conf_clk,
    input  logic [SEL_W-1:0]          i_sel,
    input  logic                      i_auto_reset_enb,
    input  logic [N_DESIGNS-1:0]      i_design_reset,
    input  logic [IO_W-1:0]           i_io_in,
    input  logic [N_DESIGNS*IO_W-1:0] i_des_io_out,
    input  logic [N_DESIGNS*IO_W-1:0] i_des_io_oeb,
    output logic [IO_W-1:0]           o_io_out,
    output logic [IO_W-1:0]           o_io_oeb,
    output logic [N_DESIGNS*IO_W-1:0] o_des_io_in,
    output logic [N_DESIGNS-1:0]      o_des_rst,
    output logic [N_DESIGNS-1:0]      o_des_ena,
    output logic [SEL_W-1:0]          o_sel,
    output logic                      o_busy
);

    localparam int unsigned      CNT_W      = cnt_width(GUARD_CYCLES, RESET_CYCLES);
    localparam logic [SEL_W-1:0] SEL_NONE   = SEL_W'(sel_none(SEL_W));
    localparam logic [SEL_W-1:0] N_SEL      = SEL_W'(N_DESIGNS);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);

    dmux_state_e              state_q, state_d;
    logic [SEL_W-1:0]         act_q, act_d;
    logic [SEL_W-1:0]         pend_q, pend_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     commit_s;

    logic [SEL_W-1:0]          route_sel_s;
    logic                      route_blank_s;
    logic [IO_W-1:0]           io_out_s;
    logic [IO_W-1:0]           io_oeb_s;
    logic [N_DESIGNS*IO_W-1:0] des_in_s;

    dmux_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (i_clk),
        .rst_n_i (i_reset_n),
        .async_i (i_conf_clk),
        .pulse_o (commit_s)
    );

    // Sequencer next state; a commit restarts the sequence from any state.
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        if (commit_s) begin
            state_d = ST_GUARD;
            cnt_d   = '0;
            pend_d  = i_sel;
        end else begin
            case (state_q)
                ST_GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        cnt_d   = '0;
                        act_d   = (pend_q < N_SEL) ? pend_q : SEL_NONE;
                        state_d = i_auto_reset_enb ? ST_RUN : ST_RESET;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RESET: begin
                    if (cnt_q == RESET_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Sequencer registers; reset aborts any sequence without switching.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= ST_RUN;
            act_q   <= SEL_NONE;
            pend_q  <= SEL_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pad routing: selected design drives the pads unless blanked.
    always_comb begin
        io_out_s = '0;
        io_oeb_s = '1;
        des_in_s = '0;
        for (int d = 0; d < int'(N_DESIGNS); d++) begin
            if (route_sel_s == SEL_W'(d)) begin
                des_in_s[d*IO_W +: IO_W] = i_io_in;
                if (!route_blank_s) begin
                    io_out_s = i_des_io_out[d*IO_W +: IO_W];
                    io_oeb_s = i_des_io_oeb[d*IO_W +: IO_W];
                end else begin
                    io_out_s = '0;
                    io_oeb_s = '1;
                end
            end else begin
                des_in_s[d*IO_W +: IO_W] = '0;
            end
        end
    end

    // Per-design reset and enable; every unselected design is held in reset.
    always_comb begin
        o_des_rst = '1;
        o_des_ena = '0;
        for (int d = 0; d < int'(N_DESIGNS); d++) begin
            o_des_rst[d] = ~i_reset_n | i_design_reset[d] | (act_q != SEL_W'(d))
                         | ((state_q == ST_RESET) & (act_q == SEL_W'(d)));
            o_des_ena[d] = (state_q == ST_RUN) & (act_q == SEL_W'(d));
        end
    end

`ifdef DMUX_REGISTERED_IO_EN
    logic [IO_W-1:0]           io_out_q;
    logic [IO_W-1:0]           io_oeb_q;
    logic [N_DESIGNS*IO_W-1:0] des_in_q;

    // Route from next-state so blanking lands in the first GUARD cycle.
    assign route_sel_s   = act_d;
    assign route_blank_s = (state_d != ST_RUN) || (act_d >= N_SEL);

    // Output registers for the pad and design-input paths.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            io_out_q <= '0;
            io_oeb_q <= '1;
            des_in_q <= '0;
        end else begin
            io_out_q <= io_out_s;
            io_oeb_q <= io_oeb_s;
            des_in_q <= des_in_s;
        end
    end

    assign o_io_out    = io_out_q;
    assign o_io_oeb    = io_oeb_q;
    assign o_des_io_in = des_in_q;
`else
    assign route_sel_s   = act_q;
    assign route_blank_s = (state_q != ST_RUN) || (act_q >= N_SEL);

    assign o_io_out    = io_out_s;
    assign o_io_oeb    = io_oeb_s;
    assign o_des_io_in = des_in_s;
`endif

    assign o_sel  = act_q;
    assign o_busy = (state_q != ST_RUN);

endmodule

// File: tb/tb_design_mux_gen2.sv
// Self-checking bench for design_mux_gen2: selection table, corner-case
// sequences and randomized traffic against an edge-count reference model.
module tb_design_mux_gen2;

    localparam int N    = 8;
    localparam int SW   = 4;
    localparam int IOW  = 38;
    localparam int SS   = 2;
    localparam int GC   = 2;
    localparam int RC   = 16;
    localparam int NONE = 15;
    localparam int VW   = N * IOW;

    typedef logic [VW-1:0] vec_t;

    typedef struct {
        logic [SW-1:0] sel;
        logic          auto_enb;
        logic [SW-1:0] exp_sel;
        logic [N-1:0]  exp_ena;
        logic [N-1:0]  exp_rst;
        int            exp_busy;
    } vec_s;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n    = 1'b0;
    logic            conf     = 1'b0;
    logic            auto_enb = 1'b0;
    logic [SW-1:0]   sel      = '0;
    logic [N-1:0]    drst     = '0;
    logic [IOW-1:0]  io_in    = '0;
    logic [VW-1:0]   dout     = '0;
    logic [VW-1:0]   doeb     = '0;

    logic [IOW-1:0]  o_out;
    logic [IOW-1:0]  o_oeb;
    logic [VW-1:0]   o_din;
    logic [N-1:0]    o_rst;
    logic [N-1:0]    o_ena;
    logic [SW-1:0]   o_sel;
    logic            o_busy;

    design_mux_gen2 #(
        .N_DESIGNS(N), .SEL_W(SW), .IO_W(IOW),
        .SYNC_STAGES(SS), .GUARD_CYCLES(GC), .RESET_CYCLES(RC)
    ) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_conf_clk       (conf),
        .i_sel            (sel),
        .i_auto_reset_enb (auto_enb),
        .i_design_reset   (drst),
        .i_io_in          (io_in),
        .i_des_io_out     (dout),
        .i_des_io_oeb     (doeb),
        .o_io_out         (o_out),
        .o_io_oeb         (o_oeb),
        .o_des_io_in      (o_din),
        .o_des_rst        (o_rst),
        .o_des_ena        (o_ena),
        .o_sel            (o_sel),
        .o_busy           (o_busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: a selection sequence is described by its commit edge;
    // everything else is arithmetic on the edge distance from that commit.
    int m_act    = NONE;
    int m_commit = 0;
    int m_new    = 0;
    int m_pend   = -1;
    bit m_seq    = 1'b0;
    bit m_prev   = 1'b0;
    bit m_auto   = 1'b0;
    bit m_busy   = 1'b0;
    bit m_rph    = 1'b0;

    logic [VW-1:0]  s_dout;
    logic [VW-1:0]  s_doeb;
    logic [IOW-1:0] s_in;

    task automatic chk(input string name, input vec_t got, input vec_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        int rel;
        cyc++;
        if (!rst_n) begin
            m_act = NONE; m_seq = 1'b0; m_pend = -1; m_prev = 1'b0;
            m_busy = 1'b0; m_rph = 1'b0;
            return;
        end
        if (m_pend == cyc) begin
            m_seq = 1'b1; m_commit = cyc; m_new = int'(sel); m_pend = -1;
        end
        if (conf && !m_prev) m_pend = cyc + SS + 1;
        m_prev = conf;
        m_busy = 1'b0;
        m_rph  = 1'b0;
        if (m_seq) begin
            rel = cyc - m_commit;
            if (rel == GC) begin
                m_act  = (m_new < N) ? m_new : NONE;
                m_auto = auto_enb;
            end
            if (rel < GC) begin
                m_busy = 1'b1;
            end else if (!m_auto && rel < GC + RC) begin
                m_busy = 1'b1;
                m_rph  = 1'b1;
            end else begin
                m_seq = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        logic [IOW-1:0] e_out, e_oeb, src_in;
        logic [VW-1:0]  e_din, src_out, src_oeb;
        logic [N-1:0]   e_rst, e_ena;
`ifdef DMUX_REGISTERED_IO_EN
        src_out = s_dout; src_oeb = s_doeb; src_in = s_in;
`else
        src_out = dout;   src_oeb = doeb;   src_in = io_in;
`endif
        e_out = '0; e_oeb = '1; e_din = '0;
        if (m_act != NONE) begin
            e_din[m_act*IOW +: IOW] = src_in;
            if (!m_busy) begin
                e_out = src_out[m_act*IOW +: IOW];
                e_oeb = src_oeb[m_act*IOW +: IOW];
            end
        end
        for (int d = 0; d < N; d++) begin
            e_rst[d] = !rst_n || drst[d] || (d != m_act) || (m_rph && d == m_act);
            e_ena[d] = !m_busy && (d == m_act);
        end
        chk("io_out",    vec_t'(o_out),  vec_t'(e_out));
        chk("io_oeb",    vec_t'(o_oeb),  vec_t'(e_oeb));
        chk("des_io_in", vec_t'(o_din),  vec_t'(e_din));
        chk("des_rst",   vec_t'(o_rst),  vec_t'(e_rst));
        chk("des_ena",   vec_t'(o_ena),  vec_t'(e_ena));
        chk("sel",       vec_t'(o_sel),  vec_t'(m_act));
        chk("busy",      vec_t'(o_busy), vec_t'(m_busy));
    endtask

    task automatic step(input bit rnd);
        @(posedge clk);
        model_edge();
        s_dout = dout; s_doeb = doeb; s_in = io_in;
        if (rnd) begin
            for (int i = 0; i < VW; i++) begin
                dout[i] = 1'($urandom);
                doeb[i] = 1'($urandom);
            end
            for (int i = 0; i < IOW; i++) io_in[i] = 1'($urandom);
        end
        #1;
        check_all();
    endtask

    task automatic do_select(input logic [SW-1:0] s, input logic a,
                             output int lat, output int nb);
        sel = s; auto_enb = a; conf = 1'b1;
        step(1'b1);
        conf = 1'b0;
        lat = 0;
        while (!o_busy && lat < 10) begin step(1'b1); lat++; end
        nb = 0;
        while (o_busy && nb < 60) begin step(1'b1); nb++; end
        repeat (4) step(1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_s vecs [8];
        int   lat, nb, n, rst_hold, hi_left, lo_cnt;
        bit   ena2;
        logic [IOW-1:0] pat_a, pat_b;

        vecs[0] = '{4'd3,  1'b0, 4'd3, 8'h08, 8'hF7, 18};
        vecs[1] = '{4'd5,  1'b1, 4'd5, 8'h20, 8'hDF, 2};
        vecs[2] = '{4'd8,  1'b0, 4'hF, 8'h00, 8'hFF, 18};
        vecs[3] = '{4'd2,  1'b1, 4'd2, 8'h04, 8'hFB, 2};
        vecs[4] = '{4'd2,  1'b0, 4'd2, 8'h04, 8'hFB, 18};
        vecs[5] = '{4'hF,  1'b1, 4'hF, 8'h00, 8'hFF, 2};
        vecs[6] = '{4'd0,  1'b0, 4'd0, 8'h01, 8'hFE, 18};
        vecs[7] = '{4'd7,  1'b1, 4'd7, 8'h80, 8'h7F, 2};

        // Reset state
        repeat (3) step(1'b1);
        rst_n = 1'b1;
        step(1'b1);
        chk("rst_sel",  vec_t'(o_sel),  vec_t'(4'hF));
        chk("rst_busy", vec_t'(o_busy), vec_t'(1'b0));
        chk("rst_des",  vec_t'(o_rst),  vec_t'(8'hFF));
        chk("rst_ena",  vec_t'(o_ena),  vec_t'(8'h00));
        chk("rst_oeb",  vec_t'(o_oeb),  vec_t'({IOW{1'b1}}));

        // Selection table
        for (int i = 0; i < 8; i++) begin
            do_select(vecs[i].sel, vecs[i].auto_enb, lat, nb);
            chk($sformatf("tbl%0d_latency", i), vec_t'(lat), vec_t'(SS + 1));
            chk($sformatf("tbl%0d_busy_len", i), vec_t'(nb), vec_t'(vecs[i].exp_busy));
            chk($sformatf("tbl%0d_sel", i), vec_t'(o_sel), vec_t'(vecs[i].exp_sel));
            chk($sformatf("tbl%0d_ena", i), vec_t'(o_ena), vec_t'(vecs[i].exp_ena));
            chk($sformatf("tbl%0d_rst", i), vec_t'(o_rst), vec_t'(vecs[i].exp_rst));
        end

        // Restrike during RESET: design 2 must never be enabled
        sel = 4'd2; auto_enb = 1'b0; conf = 1'b1;
        step(1'b1);
        conf = 1'b0;
        n = 0;
        while (!o_busy && n < 10) begin step(1'b1); n++; end
        ena2 = 1'b0;
        for (int i = 0; i < GC + 5; i++) begin step(1'b1); ena2 |= o_ena[2]; end
        sel = 4'd6; conf = 1'b1;
        step(1'b1);
        ena2 |= o_ena[2];
        conf = 1'b0;
        n = 0;
        while (o_busy && n < 80) begin step(1'b1); ena2 |= o_ena[2]; n++; end
        chk("restrike_done", vec_t'(o_busy), vec_t'(1'b0));
        chk("restrike_sel",  vec_t'(o_sel),  vec_t'(4'd6));
        chk("restrike_ena2", vec_t'(ena2),   vec_t'(1'b0));
        chk("restrike_ena6", vec_t'(o_ena),  vec_t'(8'h40));

        // Reset in GUARD aborts with no switch
        sel = 4'd4; conf = 1'b1;
        step(1'b1);
        conf = 1'b0;
        n = 0;
        while (!o_busy && n < 10) begin step(1'b1); n++; end
        chk("midguard_busy", vec_t'(o_busy), vec_t'(1'b1));
        rst_n = 1'b0;
        step(1'b1);
        chk("midguard_sel",  vec_t'(o_sel),  vec_t'(4'hF));
        chk("midguard_idle", vec_t'(o_busy), vec_t'(1'b0));
        chk("midguard_rst",  vec_t'(o_rst),  vec_t'(8'hFF));
        chk("midguard_din",  vec_t'(o_din),  vec_t'(0));
        rst_n = 1'b1;
        repeat (25) step(1'b1);
        chk("midguard_noswitch", vec_t'(o_sel), vec_t'(4'hF));

        // Manual reset and IO latency on design 1
        do_select(4'd1, 1'b0, lat, nb);
        drst = 8'h02;
        #1;
        chk("manual_rst_on",  vec_t'(o_rst[1]), vec_t'(1'b1));
        chk("manual_rst_sel", vec_t'(o_sel),    vec_t'(4'd1));
        drst = 8'h00;
        #1;
        chk("manual_rst_off", vec_t'(o_rst[1]), vec_t'(1'b0));
        pat_a = 38'h15_5555_5555;
        pat_b = 38'h2A_AAAA_AAAA;
        dout[IOW +: IOW] = pat_a;
        step(1'b0);
        dout[IOW +: IOW] = pat_b;
        #1;
`ifdef DMUX_REGISTERED_IO_EN
        chk("io_latency_pre", vec_t'(o_out), vec_t'(pat_a));
`else
        chk("io_latency_pre", vec_t'(o_out), vec_t'(pat_b));
`endif
        step(1'b0);
        chk("io_latency_post", vec_t'(o_out), vec_t'(pat_b));

        // Randomized traffic with legal strobe spacing
        rst_hold = 0; hi_left = 0; lo_cnt = 10;
        for (int i = 0; i < 1500; i++) begin
            if (rst_n && $urandom_range(199, 0) == 0) begin
                rst_n = 1'b0;
                rst_hold = $urandom_range(2, 1);
            end else if (!rst_n) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end
            if (conf) begin
                hi_left--;
                if (hi_left == 0) begin conf = 1'b0; lo_cnt = 0; end
            end else begin
                lo_cnt++;
                if (lo_cnt >= SS + 2 && $urandom_range(23, 0) == 0) begin
                    conf = 1'b1;
                    hi_left = $urandom_range(3, 1);
                    sel = 4'($urandom_range(9, 0));
                end
            end
            if ($urandom_range(31, 0) == 0) auto_enb = ~auto_enb;
            drst = ($urandom_range(7, 0) == 0) ? 8'($urandom) : 8'h00;
            step(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
